// File: rtl/bus_fifo_port.sv
// Memory-mapped mailbox: a 4-byte CPU bus window in front of a TX FIFO (CPU to device)
// and an RX FIFO (device to CPU), each with a valid/ready stream toward the device.
module bus_fifo_port #(
   parameter logic [15:0] BASE  = 16'hFF00,
   parameter int          DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addrbus,
   input  logic        rw,
   inout  wire  [7:0]  databus,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam int            AW   = $clog2(DEPTH);
   localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

   logic [7:0]    tx_mem [DEPTH];
   logic [7:0]    rx_mem [DEPTH];

   logic          rw_q, rw_d;
   logic          boot_q;
   logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [AW:0]   tx_count_q, tx_count_d, rx_count_q, rx_count_d;
   logic          tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;

   logic          sel, wr_stb, cmd;
   logic [1:0]    off;
   logic [7:0]    wdata, rdata, status;
   logic          tx_empty, tx_full, rx_empty, rx_full;
   logic          tx_push_req, tx_push, tx_pop, tx_flush;
   logic          rx_pop_req, rx_pop, rx_push, rx_flush, clr_flags;

   assign sel     = (addrbus[15:2] == BASE[15:2]);
   assign off     = addrbus[1:0];
   assign wdata   = databus;
   assign databus = (sel & ~rw) ? rdata : 8'bz;

   assign tx_empty = (tx_count_q == '0);
   assign tx_full  = (tx_count_q == FULL);
   assign rx_empty = (rx_count_q == '0);
   assign rx_full  = (rx_count_q == FULL);
   assign tx_valid = ~tx_empty;
   assign tx_data  = tx_mem[tx_rd_q];
   assign status   = {2'b00, rx_unf_q, tx_ovf_q, tx_full, tx_empty, rx_full, rx_empty};

   // The first edge after reset is never a strobe: rw may already be high when reset drops.
   assign wr_stb      = sel & rw & ~rw_q & ~boot_q;
   assign cmd         = wr_stb & (off == 2'd1);
   assign tx_push_req = wr_stb & (off == 2'd0);
   assign tx_pop      = tx_valid & tx_ready;
   assign tx_push     = tx_push_req & (~tx_full | tx_pop);
   assign tx_flush    = cmd & wdata[1];
   assign rx_pop_req  = cmd & wdata[0];
   assign rx_flush    = cmd & wdata[2];
   assign clr_flags   = cmd & wdata[3];
   assign rx_ready    = ~rx_full | rx_pop_req;
   assign rx_push     = rx_valid & rx_ready;
   assign rx_pop      = rx_pop_req & ~rx_empty;

   always_comb begin
      rdata = 8'h00;
      case (off)
         2'd0:    rdata = rx_empty ? 8'h00 : rx_mem[rx_rd_q];
         2'd1:    rdata = status;
         2'd2:    rdata = 8'(rx_count_q);
         default: rdata = 8'(tx_count_q);
      endcase
   end

   always_comb begin
      rw_d       = rw;
      tx_wr_d    = tx_wr_q + AW'(tx_push);
      tx_rd_d    = tx_rd_q + AW'(tx_pop);
      tx_count_d = tx_count_q + (AW + 1)'(tx_push) - (AW + 1)'(tx_pop);
      rx_wr_d    = rx_wr_q + AW'(rx_push);
      rx_rd_d    = rx_rd_q + AW'(rx_pop);
      rx_count_d = rx_count_q + (AW + 1)'(rx_push) - (AW + 1)'(rx_pop);
      // Flush discards any same-cycle beat on that FIFO.
      if (tx_flush) begin
         tx_wr_d    = '0;
         tx_rd_d    = '0;
         tx_count_d = '0;
      end
      if (rx_flush) begin
         rx_wr_d    = '0;
         rx_rd_d    = '0;
         rx_count_d = '0;
      end
      tx_ovf_d = (tx_ovf_q & ~clr_flags) | (tx_push_req & ~tx_push);
      rx_unf_d = (rx_unf_q & ~clr_flags) | (rx_pop_req & rx_empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rw_q       <= 1'b0;
         boot_q     <= 1'b1;
         tx_wr_q    <= '0;
         tx_rd_q    <= '0;
         tx_count_q <= '0;
         rx_wr_q    <= '0;
         rx_rd_q    <= '0;
         rx_count_q <= '0;
         tx_ovf_q   <= 1'b0;
         rx_unf_q   <= 1'b0;
      end else begin
         rw_q       <= rw_d;
         boot_q     <= 1'b0;
         tx_wr_q    <= tx_wr_d;
         tx_rd_q    <= tx_rd_d;
         tx_count_q <= tx_count_d;
         rx_wr_q    <= rx_wr_d;
         rx_rd_q    <= rx_rd_d;
         rx_count_q <= rx_count_d;
         tx_ovf_q   <= tx_ovf_d;
         rx_unf_q   <= rx_unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_q] <= wdata;
      if (rx_push) rx_mem[rx_wr_q] <= rx_data;
   end

endmodule

// File: tb/tb_bus_fifo_port.sv
// Bench for bus_fifo_port: directed scenarios plus a randomized mix, all checked
// against queue-based FIFO models of the mailbox.
module tb_bus_fifo_port;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst, rw, tx_ready, rx_valid, tx_valid, rx_ready;
   logic [15:0] addrbus;
   logic [7:0]  rx_data, tx_data, drv_val;
   logic        drv_en;
   wire  [7:0]  databus;

   assign databus = drv_en ? drv_val : 8'bz;
   pullup (databus);

   bus_fifo_port #(.BASE(16'hFF00), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .addrbus(addrbus), .rw(rw), .databus(databus),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   bit         m_ovf, m_unf;

   function automatic logic [7:0] m_status();
      return {2'b00, m_unf, m_ovf, txq.size() == DEPTH, txq.size() == 0,
              rxq.size() == DEPTH, rxq.size() == 0};
   endfunction

   function automatic logic [7:0] m_head();
      return (rxq.size() == 0) ? 8'h00 : rxq[0];
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; rw = 1'b0; drv_en = 1'b0; drv_val = 8'h00; tx_ready = 1'b0;
      rx_valid = 1'b0; rx_data = 8'h00; addrbus = 16'h0000;
      cycle();
      rst = 1'b0;
      cycle();
      txq.delete(); rxq.delete(); m_ovf = 0; m_unf = 0;
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
      addrbus = a; rw = 1'b0; drv_en = 1'b0;
      #1;
      d = databus;
      addrbus = 16'h0000;
   endtask

   // Device-side handshakes are asserted only across the strobe edge.
   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int hold,
                            input bit pop_tx, input bit push_rx, input logic [7:0] rxd);
      addrbus = a; rw = 1'b1; drv_en = 1'b1; drv_val = d;
      tx_ready = pop_tx; rx_valid = push_rx; rx_data = rxd;
      cycle();
      tx_ready = 1'b0; rx_valid = 1'b0;
      repeat (hold - 1) cycle();
      rw = 1'b0; drv_en = 1'b0; addrbus = 16'h0000;
      cycle();
   endtask

   task automatic model_write(input logic [15:0] a, input logic [7:0] d, input bit pop_tx,
                              input bit push_rx, input logic [7:0] rxd);
      int tx_n, rx_n;
      bit in_win, cmd, popped, rx_ok, set_ovf, set_unf;
      tx_n    = txq.size();
      rx_n    = rxq.size();
      in_win  = (a[15:2] == 14'h3FC0);
      cmd     = in_win && (a[1:0] == 2'd1);
      popped  = pop_tx && (tx_n > 0);
      rx_ok   = push_rx && ((rx_n < DEPTH) || (cmd && d[0]));
      set_ovf = 0;
      set_unf = 0;
      if (popped) void'(txq.pop_front());
      if (in_win && a[1:0] == 2'd0) begin
         if (tx_n < DEPTH || popped) txq.push_back(d);
         else set_ovf = 1;
      end
      if (cmd && d[0]) begin
         if (rx_n == 0) set_unf = 1;
         else void'(rxq.pop_front());
      end
      if (rx_ok) rxq.push_back(rxd);
      if (cmd && d[1]) txq.delete();
      if (cmd && d[2]) rxq.delete();
      if (cmd && d[3]) begin m_ovf = 0; m_unf = 0; end
      m_ovf = m_ovf | set_ovf;
      m_unf = m_unf | set_unf;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      cpu_write(a, d, 1, 0, 0, 8'h00);
      model_write(a, d, 0, 0, 8'h00);
   endtask

   task automatic dev_push_rx(input logic [7:0] b);
      rx_valid = 1'b1; rx_data = b;
      cycle();
      rx_valid = 1'b0;
      if (rxq.size() < DEPTH) rxq.push_back(b);
   endtask

   task automatic dev_pop_tx();
      tx_ready = 1'b1;
      cycle();
      tx_ready = 1'b0;
      if (txq.size() > 0) void'(txq.pop_front());
   endtask

   task automatic test_reset();
      logic [7:0] d;
      do_reset();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
      cpu_read(16'hFF01, d);
      checks++; if (d !== 8'h05) begin errors++; $display("FAIL reset_status got=%h exp=05", d); end
      cpu_read(16'hFF00, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_rx_head got=%h exp=00", d); end
      cpu_read(16'hFF03, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_tx_count got=%h exp=00", d); end
      cpu_read(16'h0000, d);
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL bus_released got=%h exp=FF(pulled)", d); end
   endtask

   task automatic test_write_hold();
      logic [7:0] b, d;
      do_reset();
      b = 8'($urandom);
      addrbus = 16'hFF00; rw = 1'b1; drv_en = 1'b1; drv_val = b;
      cycle();
      checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL push_latency got=%b exp=1", tx_valid); end
      checks++; if (tx_data !== b) begin errors++; $display("FAIL push_data got=%h exp=%h", tx_data, b); end
      cycle();
      cycle();
      rw = 1'b0; drv_en = 1'b0; addrbus = 16'h0000;
      cycle();
      cpu_read(16'hFF03, d);
      checks++; if (d !== 8'd1) begin errors++; $display("FAIL held_rw_single_push got=%0d exp=1", d); end
      tx_ready = 1'b1;
      cycle();
      tx_ready = 1'b0;
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL pop_empties got=%b exp=0", tx_valid); end
   endtask

   task automatic test_tx_overflow();
      logic [7:0] b, d;
      do_reset();
      for (int i = 0; i < DEPTH; i++) wr(16'hFF00, 8'($urandom));
      cpu_read(16'hFF03, d);
      checks++; if (d !== 8'(DEPTH)) begin errors++; $display("FAIL tx_fill got=%0d exp=%0d", d, DEPTH); end
      b = 8'($urandom);
      checks++; if (tx_data !== txq[0]) begin errors++; $display("FAIL tx_head_full got=%h exp=%h", tx_data, txq[0]); end
      cpu_write(16'hFF00, b, 2, 1, 0, 8'h00);
      model_write(16'hFF00, b, 1, 0, 8'h00);
      cpu_read(16'hFF01, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL full_push_pop_status got=%h exp=%h", d, m_status()); end
      cpu_read(16'hFF03, d);
      checks++; if (d !== 8'(txq.size())) begin errors++; $display("FAIL full_push_pop_count got=%0d exp=%0d", d, txq.size()); end
      wr(16'hFF00, 8'($urandom));
      cpu_read(16'hFF01, d);
      checks++; if (d !== m_status() || d[4] !== 1'b1) begin errors++; $display("FAIL tx_ovf_set got=%h exp=%h", d, m_status()); end
      wr(16'hFF01, 8'h08);
      cpu_read(16'hFF01, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL tx_ovf_clear got=%h exp=%h", d, m_status()); end
      for (int i = 0; i < DEPTH && txq.size() > 0; i++) begin
         checks++; if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin errors++; $display("FAIL tx_order[%0d] got=%h/%b exp=%h", i, tx_data, tx_valid, txq[0]); end
         dev_pop_tx();
      end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained got=%b exp=0", tx_valid); end
   endtask

   task automatic test_rx_basic();
      logic [7:0] d;
      do_reset();
      dev_push_rx(8'h11);
      dev_push_rx(8'h22);
      cpu_read(16'hFF00, d);
      checks++; if (d !== 8'h11) begin errors++; $display("FAIL rx_head got=%h exp=11", d); end
      cpu_read(16'hFF02, d);
      checks++; if (d !== 8'd2) begin errors++; $display("FAIL rx_count got=%0d exp=2", d); end
      wr(16'hFF01, 8'h01);
      cpu_read(16'hFF00, d);
      checks++; if (d !== 8'h22) begin errors++; $display("FAIL rx_pop_head got=%h exp=22", d); end
      wr(16'hFF01, 8'h01);
      cpu_read(16'hFF01, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL rx_last_pop_status got=%h exp=%h", d, m_status()); end
      wr(16'hFF01, 8'h01);
      cpu_read(16'hFF01, d);
      checks++; if (d !== m_status() || d[5] !== 1'b1) begin errors++; $display("FAIL rx_unf_set got=%h exp=%h", d, m_status()); end
   endtask

   task automatic test_rx_full();
      logic [7:0] b, d;
      do_reset();
      for (int i = 0; i < DEPTH; i++) dev_push_rx(8'($urandom));
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_full got=%b exp=0", rx_ready); end
      b = 8'($urandom);
      cpu_write(16'hFF01, 8'h01, 1, 0, 1, b);
      model_write(16'hFF01, 8'h01, 0, 1, b);
      cpu_read(16'hFF02, d);
      checks++; if (d !== 8'(rxq.size())) begin errors++; $display("FAIL full_pop_push_count got=%0d exp=%0d", d, rxq.size()); end
      cpu_read(16'hFF00, d);
      checks++; if (d !== m_head()) begin errors++; $display("FAIL full_pop_push_head got=%h exp=%h", d, m_head()); end
      b = 8'($urandom);
      cpu_write(16'hFF01, 8'h04, 1, 0, 1, b);
      model_write(16'hFF01, 8'h04, 0, 1, b);
      cpu_read(16'hFF02, d);
      checks++; if (d !== 8'd0) begin errors++; $display("FAIL rx_flush_count got=%0d exp=0", d); end
      cpu_read(16'hFF01, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL rx_flush_status got=%h exp=%h", d, m_status()); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      do_reset();
      for (int i = 0; i < 5; i++) wr(16'hFF00, 8'($urandom));
      dev_push_rx(8'($urandom));
      wr(16'hFF01, 8'h01);
      wr(16'hFF01, 8'h01);
      addrbus = 16'hFF00; rw = 1'b1; drv_en = 1'b1; drv_val = 8'($urandom); rst = 1'b1;
      cycle();
      rst = 1'b0;
      txq.delete(); rxq.delete(); m_ovf = 0; m_unf = 0;
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midreset_tx_valid got=%b exp=0", tx_valid); end
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL midreset_rx_ready got=%b exp=1", rx_ready); end
      cycle();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_push got=%b exp=0", tx_valid); end
      rw = 1'b0; drv_en = 1'b0; addrbus = 16'h0000;
      cycle();
      cpu_read(16'hFF01, d);
      checks++; if (d !== 8'h05) begin errors++; $display("FAIL midreset_status got=%h exp=05", d); end
      cpu_read(16'hFF03, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL midreset_tx_count got=%0d exp=0", d); end
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [7:0]  d, b, r;
      int          op, hold;
      bit          p;
      do_reset();
      for (int it = 0; it < 300; it++) begin
         op = $urandom_range(0, 9);
         b  = 8'($urandom);
         r  = 8'($urandom);
         p  = 1'($urandom);
         hold = $urandom_range(1, 3);
         if (op <= 3) begin
            cpu_write(16'hFF00, b, hold, p, 0, r);
            model_write(16'hFF00, b, p, 0, r);
         end else if (op == 4) begin
            b = b & 8'($urandom) & 8'($urandom);
            cpu_write(16'hFF01, b, hold, 0, p, r);
            model_write(16'hFF01, b, 0, p, r);
         end else if (op == 5) begin
            case ($urandom_range(0, 2))
               0:       a = 16'hFF02;
               1:       a = 16'hFF03;
               default: a = 16'hFF04;
            endcase
            cpu_write(a, b, hold, p, 0, r);
            model_write(a, b, p, 0, r);
         end else if (op <= 7) begin
            dev_push_rx(r);
         end else begin
            dev_pop_tx();
         end
         checks++; if (tx_valid !== (txq.size() > 0)) begin errors++; $display("FAIL rnd_tx_valid it=%0d got=%b exp=%b", it, tx_valid, txq.size() > 0); end
         if (txq.size() > 0) begin
            checks++; if (tx_data !== txq[0]) begin errors++; $display("FAIL rnd_tx_data it=%0d got=%h exp=%h", it, tx_data, txq[0]); end
         end
         checks++; if (rx_ready !== (rxq.size() < DEPTH)) begin errors++; $display("FAIL rnd_rx_ready it=%0d got=%b exp=%b", it, rx_ready, rxq.size() < DEPTH); end
         cpu_read(16'hFF00, d);
         checks++; if (d !== m_head()) begin errors++; $display("FAIL rnd_rx_head it=%0d got=%h exp=%h", it, d, m_head()); end
         cpu_read(16'hFF01, d);
         checks++; if (d !== m_status()) begin errors++; $display("FAIL rnd_status it=%0d got=%h exp=%h", it, d, m_status()); end
         cpu_read(16'hFF02, d);
         checks++; if (d !== 8'(rxq.size())) begin errors++; $display("FAIL rnd_rx_count it=%0d got=%0d exp=%0d", it, d, rxq.size()); end
         cpu_read(16'hFF03, d);
         checks++; if (d !== 8'(txq.size())) begin errors++; $display("FAIL rnd_tx_count it=%0d got=%0d exp=%0d", it, d, txq.size()); end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      test_reset();
      test_write_hold();
      test_tx_overflow();
      test_rx_basic();
      test_rx_full();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
